galena_state_ref_player: RTL and testbench

- Parametrised reference-state buffer for the galena analog-macro behaviour model.
- Generalises the fixed two-source interleaved state reference to NUM_CH channels and arbitrary depth.
- States are loaded per channel at runtime, then played back in interleaved order through a valid/ready stream with a programmable per-state spin delay.
- Sits between the testbench/loader and the digital spin-readout path. Optionally scores DUT states against the reference.

---
 rtl/galena_state_ref_player.sv | 177 +++++++++++++++++
 tb/tb_galena_state_ref_player.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/galena_state_ref_player.sv
// Reference-state buffer: per-channel loads, interleaved playback over valid/ready, optional scoring (GALENA_STATE_CMP_EN).
// Latency: state_valid_o rises max(delay,1)+1 cycles after start or after each handshake; done_o one cycle after the last handshake.
// Backpressure: a presented state holds until state_ready_i; loads stall via load_ready_o outside IDLE or when the channel is full.
module galena_state_ref_player #(
    parameter int NUM_SPIN = 256,
    parameter int DEPTH    = 4,
    parameter int NUM_CH   = 2,
    parameter int DELAY_W  = 4,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                load_valid_i,
    output logic                load_ready_o,
    input  logic [CH_W-1:0]     load_ch_i,
    input  logic [NUM_SPIN-1:0] load_data_i,
    input  logic                start_i,
    input  logic [DELAY_W-1:0]  delay_i,
    output logic                busy_o,
    output logic                full_o,
    output logic                state_valid_o,
    input  logic                state_ready_i,
    output logic [NUM_SPIN-1:0] state_o,
    output logic [IDX_W-1:0]    state_idx_o,
    output logic                done_o,
    input  logic [NUM_SPIN-1:0] cmp_state_i,
    output logic                mismatch_o,
    output logic [CNT_W-1:0]    mismatch_cnt_o
);

    localparam int PER   = DEPTH / NUM_CH;
    localparam int PTR_W = $clog2(PER + 1);

    typedef enum logic [1:0] {IDLE, WAIT, PRESENT, DONE} fsm_t;

    fsm_t                state_q, state_nxt;
    logic [NUM_SPIN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    ptr [NUM_CH];
    logic [NUM_CH-1:0]   ch_full;
    logic                sel_full;
    logic                full_all;
    logic [IDX_W-1:0]    wr_addr;
    logic                load_fire;
    logic [DELAY_W-1:0]  cnt_q, d_q, d_sel;
    logic [IDX_W-1:0]    idx_q, state_idx_q;
    logic [NUM_SPIN-1:0] state_dat_q;
    logic                start_go, hs, last_idx;

    // Channel-full flags and the selected channel's write address; an
    // out-of-range channel leaves sel_full high so it can never be accepted.
    always_comb begin
        sel_full = 1'b1;
        wr_addr  = '0;
        full_all = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_full[c] = (ptr[c] == PTR_W'(PER));
            full_all   = full_all & ch_full[c];
            if (load_ch_i == CH_W'(c)) begin
                sel_full = ch_full[c];
                wr_addr  = IDX_W'(NUM_CH * int'(ptr[c]) + c);
            end
        end
    end

    assign load_ready_o = ~rst_i & (state_q == IDLE) & ~clear_i & ~sel_full;
    assign load_fire    = load_valid_i & load_ready_o;
    assign full_o       = full_all;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) ptr[c] <= '0;
        end else if (state_q == IDLE && clear_i) begin
            for (int c = 0; c < NUM_CH; c++) ptr[c] <= '0;
        end else if (load_fire) begin
            for (int c = 0; c < NUM_CH; c++)
                if (load_ch_i == CH_W'(c)) ptr[c] <= ptr[c] + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_fire) mem[wr_addr] <= load_data_i;
    end

    assign d_sel    = (delay_i == '0) ? DELAY_W'(1) : delay_i;
    assign last_idx = (idx_q == IDX_W'(DEPTH - 1));

    always_comb begin
        state_nxt = state_q;
        start_go  = 1'b0;
        hs        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && full_all) begin
                    state_nxt = WAIT;
                    start_go  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == DELAY_W'(1)) state_nxt = PRESENT;
            end
            PRESENT: begin
                if (state_ready_i) begin
                    hs        = 1'b1;
                    state_nxt = last_idx ? DONE : WAIT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            d_q         <= '0;
            idx_q       <= '0;
            state_dat_q <= '0;
            state_idx_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (start_go) begin
                d_q   <= d_sel;
                cnt_q <= d_sel;
                idx_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == DELAY_W'(1)) begin
                    state_dat_q <= mem[idx_q];
                    state_idx_q <= idx_q;
                end
            end else if (hs && !last_idx) begin
                idx_q <= idx_q + 1'b1;
                cnt_q <= d_q;
            end
        end
    end

    assign state_valid_o = (state_q == PRESENT);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign state_o       = state_dat_q;
    assign state_idx_o   = state_idx_q;

`ifdef GALENA_STATE_CMP_EN
    logic             mism_q;
    logic [CNT_W-1:0] mcnt_q;
    logic             differs;

    assign differs = (cmp_state_i != state_dat_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mism_q <= 1'b0;
            mcnt_q <= '0;
        end else begin
            mism_q <= hs & differs;
            if (start_go)
                mcnt_q <= '0;
            else if (hs && differs && mcnt_q != {CNT_W{1'b1}})
                mcnt_q <= mcnt_q + 1'b1;
        end
    end

    assign mismatch_o     = mism_q;
    assign mismatch_cnt_o = mcnt_q;
`else
    logic unused_cmp;
    assign unused_cmp     = ^cmp_state_i;
    assign mismatch_o     = 1'b0;
    assign mismatch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_galena_state_ref_player.sv
// Directed bench for galena_state_ref_player with NUM_CH=2, DEPTH=4, 16-bit states.
module tb_galena_state_ref_player;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        load_valid_i = 1'b0;
    logic        load_ready_o;
    logic [0:0]  load_ch_i = '0;
    logic [15:0] load_data_i = '0;
    logic        start_i = 1'b0;
    logic [3:0]  delay_i = '0;
    logic        busy_o, full_o, state_valid_o, done_o, mismatch_o;
    logic        state_ready_i = 1'b0;
    logic [15:0] state_o;
    logic [1:0]  state_idx_o;
    logic [15:0] cmp_state_i = '0;
    logic [15:0] mismatch_cnt_o;

    int checks = 0;
    int failures = 0;

    galena_state_ref_player #(
        .NUM_SPIN(16), .DEPTH(4), .NUM_CH(2), .DELAY_W(4), .CNT_W(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
        .load_ch_i(load_ch_i), .load_data_i(load_data_i),
        .start_i(start_i), .delay_i(delay_i), .busy_o(busy_o), .full_o(full_o),
        .state_valid_o(state_valid_o), .state_ready_i(state_ready_i),
        .state_o(state_o), .state_idx_o(state_idx_o), .done_o(done_o),
        .cmp_state_i(cmp_state_i), .mismatch_o(mismatch_o),
        .mismatch_cnt_o(mismatch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic ch, input logic [15:0] dat, input logic exp_rdy, input string tag);
        load_valid_i = 1'b1;
        load_ch_i    = ch;
        load_data_i  = dat;
        #1;
        check(tag, {31'd0, load_ready_o}, {31'd0, exp_rdy});
        tick();
        load_valid_i = 1'b0;
    endtask

    // Full playback with an always-ready consumer; odd indices get a corrupted
    // compare word so the optional scorer sees exactly two mismatches.
    task automatic play(input logic [3:0] d, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_s [4];
        int lat;
        int n;
        logic exp_mism;
        exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
        lat = (d == 4'd0) ? 2 : int'(d) + 1;
        delay_i = d;
        state_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        delay_i = 4'hF;
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
        check("mcnt_cleared_on_start", {16'd0, mismatch_cnt_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            n = 1;
            while (!state_valid_o && n < 40) begin
                tick();
                n++;
            end
            check($sformatf("latency_%0d", i), n, lat);
            check($sformatf("state_%0d", i), {16'd0, state_o}, {16'd0, exp_s[i]});
            check($sformatf("idx_%0d", i), {30'd0, state_idx_o}, i);
            cmp_state_i = exp_s[i] ^ ((i % 2 == 1) ? 16'h0001 : 16'h0000);
            tick();
`ifdef GALENA_STATE_CMP_EN
            exp_mism = (i % 2 == 1);
`else
            exp_mism = 1'b0;
`endif
            check($sformatf("mismatch_%0d", i), {31'd0, mismatch_o}, {31'd0, exp_mism});
            check($sformatf("valid_drop_%0d", i), {31'd0, state_valid_o}, 32'd0);
        end
        check("done_pulse", {31'd0, done_o}, 32'd1);
        tick();
        check("done_single", {31'd0, done_o}, 32'd0);
        check("busy_idle", {31'd0, busy_o}, 32'd0);
`ifdef GALENA_STATE_CMP_EN
        check("mcnt_final", {16'd0, mismatch_cnt_o}, 32'd2);
`else
        check("mcnt_final", {16'd0, mismatch_cnt_o}, 32'd0);
`endif
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, state_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_full", {31'd0, full_o}, 32'd0);
        check("rst_state", {16'd0, state_o}, 32'd0);
        check("rst_idx", {30'd0, state_idx_o}, 32'd0);
        check("rst_ready", {31'd0, load_ready_o}, 32'd0);
        check("rst_mism", {31'd0, mismatch_o}, 32'd0);
        check("rst_mcnt", {16'd0, mismatch_cnt_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        // Overfilling ch0 is refused; start with only ch0 full is ignored
        load(1'b0, 16'hA000, 1'b1, "ld_a0");
        load(1'b0, 16'hA111, 1'b1, "ld_a1");
        load(1'b0, 16'hA222, 1'b0, "ld_a2_rejected");
        check("full_ch0_only", {31'd0, full_o}, 32'd0);
        start_i = 1'b1;
        tick();
        tick();
        check("start_ignored", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0;
        load(1'b1, 16'hB000, 1'b1, "ld_b0");
        check("full_partial", {31'd0, full_o}, 32'd0);
        load(1'b1, 16'hB111, 1'b1, "ld_b1");
        check("full_all", {31'd0, full_o}, 32'd1);

        // Interleaved playback, delay 3
        play(4'd3, 16'hA000, 16'hB000, 16'hA111, 16'hB111);

        // Delay 0 with consumer stall, then reset mid-playback at idx 2
        delay_i = 4'd0;
        state_ready_i = 1'b0;
        cmp_state_i = 16'hA000;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("replay_mcnt_clr", {16'd0, mismatch_cnt_o}, 32'd0);
        n = 1;
        while (!state_valid_o && n < 40) begin
            tick();
            n++;
        end
        check("d0_latency", n, 32'd2);
        delay_i = 4'd7;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_valid_%0d", k), {31'd0, state_valid_o}, 32'd1);
            check($sformatf("stall_state_%0d", k), {16'd0, state_o}, 32'hA000);
            check($sformatf("stall_idx_%0d", k), {30'd0, state_idx_o}, 32'd0);
            tick();
        end
        state_ready_i = 1'b1;
        tick();
        n = 1;
        while (!state_valid_o && n < 40) begin
            tick();
            n++;
        end
        check("latched_d_latency", n, 32'd2);
        check("d0_state1", {16'd0, state_o}, 32'hB000);
        cmp_state_i = 16'hB000;
        tick();
        n = 1;
        while (!state_valid_o && n < 40) begin
            tick();
            n++;
        end
        check("d0_idx2", {30'd0, state_idx_o}, 32'd2);
        state_ready_i = 1'b0;
        tick();
        check("held_idx2", {31'd0, state_valid_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        check("abort_valid", {31'd0, state_valid_o}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        check("abort_full", {31'd0, full_o}, 32'd0);
        check("abort_state", {16'd0, state_o}, 32'd0);
        check("abort_idx", {30'd0, state_idx_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        check("abort_no_done", {31'd0, done_o}, 32'd0);
        tick();
        check("abort_still_idle", {31'd0, busy_o | done_o}, 32'd0);

        // Reload after reset and replay
        load(1'b0, 16'hC0C0, 1'b1, "ld_c0");
        load(1'b1, 16'hD0D0, 1'b1, "ld_d0");
        load(1'b0, 16'hC1C1, 1'b1, "ld_c1");
        load(1'b1, 16'hD1D1, 1'b1, "ld_d1");
        play(4'd1, 16'hC0C0, 16'hD0D0, 16'hC1C1, 16'hD1D1);

        // clear_i beats a same-cycle load and rewinds every pointer
        clear_i = 1'b1;
        load(1'b0, 16'hEEEE, 1'b0, "clear_blocks_load");
        clear_i = 1'b0;
        check("clear_full", {31'd0, full_o}, 32'd0);
        load(1'b1, 16'h9ABC, 1'b1, "ld_after_clear_ch1");
        load(1'b0, 16'h1234, 1'b1, "ld_after_clear_ch0");
        load(1'b0, 16'h5678, 1'b1, "ld_after_clear_ch0b");
        check("refill_partial", {31'd0, full_o}, 32'd0);
        load(1'b1, 16'hDEF0, 1'b1, "ld_after_clear_ch1b");
        check("refill_full", {31'd0, full_o}, 32'd1);
        play(4'd2, 16'h1234, 16'h9ABC, 16'h5678, 16'hDEF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
